// File: rtl/demux4_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
package demux4_reg_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    function automatic logic [NUM_CH-1:0] selOneHot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux4_reg_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush wins over write, write wins over drain so a same-cycle refill keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry buffers and
// an accepted-transfer counter.
module demux4_reg
    import demux4_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  y0,
    output logic [WIDTH-1:0]  y1,
    output logic [WIDTH-1:0]  y2,
    output logic [WIDTH-1:0]  y3,
    output logic [CNTW-1:0]   xfer_cnt
);

    logic              accept;
    logic [NUM_CH-1:0] wrEn;
    logic [WIDTH-1:0]  slotData [NUM_CH];
    logic [CNTW-1:0]   xferCnt_q, xferCnt_d;

    // Only the addressed channel's occupancy gates the producer, so a stalled
    // consumer never blocks traffic to the other three.
    assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;
    assign wrEn     = accept ? selOneHot(in_sel) : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : gSlot
        demux_slot #(.WIDTH(WIDTH)) uSlot (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .wr_en    (wrEn[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (slotData[k])
        );
    end

    assign y0 = slotData[0];
    assign y1 = slotData[1];
    assign y2 = slotData[2];
    assign y3 = slotData[3];

    assign xferCnt_d = accept ? xferCnt_q + CNTW'(1) : xferCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xferCnt_q <= '0;
        end else begin
            xferCnt_q <= xferCnt_d;
        end
    end

    assign xfer_cnt = xferCnt_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Scoreboard bench for demux4_reg: stimulus pushes expected words per channel,
// a negedge monitor pops and compares on every drain.
module tb_demux4_reg;

    localparam int WIDTH = 32;
    localparam int CNTW  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic [CNTW-1:0]  xfer_cnt;

    logic [WIDTH-1:0] yv [4];
    logic [WIDTH-1:0] expq [4][$];
    logic [3:0]       mv;
    int               mcnt;
    int               nTests = 0;
    int               nFail  = 0;
    int               nDrain3 = 0;

    demux4_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every drain must present the oldest word the scoreboard expects on that channel.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (k == 3) nDrain3++;
                    if (expq[k].size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("[TB] FAIL drain ch%0d: got unexpected %0h expected none", k, yv[k]);
                    end else begin
                        checkOutput($sformatf("drain ch%0d", k), yv[k], expq[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic resetModel();
        mv   = 4'b0000;
        mcnt = 0;
        for (int k = 0; k < 4; k++) expq[k].delete();
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] data,
                                 input logic [3:0] ordy, input logic fl);
        logic       expReady;
        logic       acc;
        logic [3:0] nv;
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        #2;
        expReady = !fl && (!mv[sel] || ordy[sel]);
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
        acc = v && expReady;
        if (acc) expq[sel].push_back(data);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fl)                          nv[k] = 1'b0;
            else if (acc && sel == 2'(k))    nv[k] = 1'b1;
            else if (mv[k] && ordy[k])       nv[k] = 1'b0;
            else                             nv[k] = mv[k];
        end
        mv = nv;
        if (acc) mcnt = (mcnt + 1) % 16;
        if (fl) for (int k = 0; k < 4; k++) expq[k].delete();
        checkOutput("out_valid", {28'b0, out_valid}, {28'b0, mv});
        checkOutput("xfer_cnt", {28'b0, xfer_cnt}, mcnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 4'b0000;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("reset y0", y0, 32'h0);
        checkOutput("reset y1", y1, 32'h0);
        checkOutput("reset y2", y2, 32'h0);
        checkOutput("reset y3", y3, 32'h0);
        checkOutput("reset xfer_cnt", {28'b0, xfer_cnt}, 32'h0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", {31'b0, in_ready}, 32'h1);

        // Routing: one word per channel, each drains the cycle after it lands.
        applyStimulus(1'b1, 2'd0, 32'hA0, 4'b1111, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'hA1, 4'b1111, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hA2, 4'b1111, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'hA3, 4'b1111, 1'b0);
        checkOutput("routing xfer_cnt", {28'b0, xfer_cnt}, 32'd4);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);

        // Backpressure on channel 2 must not block channel 1.
        applyStimulus(1'b1, 2'd2, 32'h55, 4'b1011, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'h66, 4'b1011, 1'b0);
        checkOutput("held y2", y2, 32'h55);
        applyStimulus(1'b1, 2'd1, 32'h77, 4'b1011, 1'b0);
        checkOutput("stable y2", y2, 32'h55);
        applyStimulus(1'b1, 2'd2, 32'h66, 4'b1111, 1'b0);
        checkOutput("refill y2", y2, 32'h66);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        checkOutput("backpressure xfer_cnt", {28'b0, xfer_cnt}, 32'd7);

        // Streaming: eight back-to-back words into channel 3.
        nDrain3 = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd3, 32'h300 + i, 4'b1111, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        checkOutput("stream drains", nDrain3, 32'd8);
        checkOutput("stream xfer_cnt", {28'b0, xfer_cnt}, 32'd15);

        // Flush: fill every channel, then clear them all in one cycle.
        applyStimulus(1'b1, 2'd0, 32'hF0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd1, 32'hF1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 32'hF2, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd3, 32'hF3, 4'b0000, 1'b0);
        checkOutput("full out_valid", {28'b0, out_valid}, 32'hF);
        applyStimulus(1'b1, 2'd1, 32'hDEAD, 4'b0000, 1'b1);
        checkOutput("flush out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("flush xfer_cnt", {28'b0, xfer_cnt}, 32'd3);
        checkOutput("flush keeps y1", y1, 32'hF1);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);

        // Counter wrap from a fresh reset: 17 accepts on a 4-bit counter land on 1.
        #1;
        rst_n = 1'b0;
        resetModel();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 2'd0, 32'h1000 + i, 4'b1111, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        checkOutput("wrap xfer_cnt", {28'b0, xfer_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
